datamem_responder: RTL and testbench

Standalone byte-addressed data memory that answers load/store requests from the core's memory stage over a valid/ready request/response handshake. Unlike a single-cycle inline array, it models configurable wait states and splits misaligned accesses that straddle a word boundary into two word beats. It is the responder end of the data-memory port and replaces the memory array embedded in the pipeline once the pipeline is made stall-aware.

---
 rtl/datamem_pkg.sv | 26 ++
 rtl/datamem_load_align.sv | 25 ++
 rtl/datamem_responder.sv | 176 +++++++++++++++++
 tb/tb_datamem_responder.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/datamem_pkg.sv
// Shared definitions for the data-memory responder and its load alignment helper.
package datamem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ACCESS0,
    ACCESS1,
    RESP
  } datamem_state_t;

  function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   size_bytes = 3'd1;
      2'b01:   size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/datamem_load_align.sv
// Combinational load alignment: merges two beat words, shifts by byte offset, extends per funct3.
// No latency, no flow control.
module datamem_load_align (
  input  logic [31:0] word0,
  input  logic [31:0] word1,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);
  import datamem_pkg::*;

  logic [31:0] raw;

  always_comb begin
    raw = 32'({word1, word0} >> {offset, 3'b000});
    case (funct3)
      F3_B:    data = {{24{raw[7]}}, raw[7:0]};
      F3_H:    data = {{16{raw[15]}}, raw[15:0]};
      F3_BU:   data = {24'h0, raw[7:0]};
      F3_HU:   data = {16'h0, raw[15:0]};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/datamem_responder.sv
// Byte-addressed data memory behind a valid/ready request/response port; one request in flight.
// Response after WAIT_CYCLES+1 cycles (+1 when split); holds in RESP while resp_ready is low.
module datamem_responder #(
  parameter int DEPTH_WORDS = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr_enable,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wr_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rd_data,
  output logic        resp_error
);
  import datamem_pkg::*;

  localparam int          AW    = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS * 4);

  logic [3:0][7:0] mem [DEPTH_WORDS];

  datamem_state_t  state;
  logic [3:0]      wait_cnt;
  logic            wr_q;
  logic            err_q;
  logic [2:0]      f3_q;
  logic [AW+1:0]   addr_q;
  logic [31:0]     wdat_q;
  logic [31:0]     word0_q;

  logic [2:0]      req_size;
  logic [32:0]     req_last;
  logic            f3_bad;
  logic            req_err;

  logic [2:0]      size_q;
  logic [1:0]      off;
  logic            split;
  logic [3:0]      size_mask;
  logic [7:0]      be64;
  logic [63:0]     wdat64;
  logic [AW-1:0]   base_idx;
  logic [AW-1:0]   cur_idx;
  logic [3:0]      cur_be;
  logic [31:0]     cur_wdat;
  logic [31:0]     rd_word;
  logic [31:0]     align_word0;
  logic [31:0]     load_dat;
  logic            mem_we;

  // Legality is decided at accept; the last-byte check is 33 bits wide so addresses never wrap.
  always_comb begin
    req_size = size_bytes(req_funct3);
    req_last = {1'b0, req_addr} + 33'(req_size) - 33'd1;
    if (req_wr_enable)
      f3_bad = req_funct3[2] || (req_funct3[1:0] == 2'b11);
    else
      f3_bad = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111);
    req_err = f3_bad || (req_last >= LIMIT);
  end

  always_comb begin
    size_q    = size_bytes(f3_q);
    off       = addr_q[1:0];
    split     = ({2'b00, off} + {1'b0, size_q}) > 4'd4;
    case (size_q)
      3'd1:    size_mask = 4'b0001;
      3'd2:    size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
    be64      = {4'b0000, size_mask} << off;
    wdat64    = {32'h0, wdat_q} << {off, 3'b000};
    base_idx  = addr_q[AW+1:2];
    cur_idx   = (state == ACCESS1) ? base_idx + 1'b1 : base_idx;
    cur_be    = (state == ACCESS1) ? be64[7:4] : be64[3:0];
    cur_wdat  = (state == ACCESS1) ? wdat64[63:32] : wdat64[31:0];
    rd_word   = mem[cur_idx];
    align_word0 = (state == ACCESS1) ? word0_q : rd_word;
    mem_we    = wr_q && !err_q && ((state == ACCESS0) || (state == ACCESS1));
  end

  datamem_load_align u_align (
    .word0  (align_word0),
    .word1  (rd_word),
    .offset (off),
    .funct3 (f3_q),
    .data   (load_dat)
  );

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (cur_be[i]) mem[cur_idx][i] <= cur_wdat[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_rd_data <= 32'h0;
      resp_error   <= 1'b0;
      wait_cnt     <= 4'd0;
      wr_q         <= 1'b0;
      err_q        <= 1'b0;
      f3_q         <= 3'd0;
      addr_q       <= '0;
      wdat_q       <= 32'h0;
      word0_q      <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            wr_q      <= req_wr_enable;
            err_q     <= req_err;
            f3_q      <= req_funct3;
            addr_q    <= req_addr[AW+1:0];
            wdat_q    <= req_wr_data;
            req_ready <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state <= ACCESS0;
            end else begin
              state    <= WAIT;
              wait_cnt <= 4'(WAIT_CYCLES - 1);
            end
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) state <= ACCESS0;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        // Errors still pass through ACCESS0 so they share the single-word response timing.
        ACCESS0: begin
          if (err_q) begin
            resp_error   <= 1'b1;
            resp_rd_data <= 32'h0;
            resp_valid   <= 1'b1;
            state        <= RESP;
          end else if (split) begin
            word0_q <= rd_word;
            state   <= ACCESS1;
          end else begin
            resp_error   <= 1'b0;
            resp_rd_data <= wr_q ? 32'h0 : load_dat;
            resp_valid   <= 1'b1;
            state        <= RESP;
          end
        end
        ACCESS1: begin
          resp_error   <= 1'b0;
          resp_rd_data <= wr_q ? 32'h0 : load_dat;
          resp_valid   <= 1'b1;
          state        <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid   <= 1'b0;
            resp_error   <= 1'b0;
            resp_rd_data <= 32'h0;
            req_ready    <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_datamem_responder.sv
// Directed bench for datamem_responder: vector table plus stall and mid-operation reset sequences.
module tb_datamem_responder;

  localparam int DW = 32;
  localparam int WC = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr_enable = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wr_data = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rd_data;
  logic        resp_error;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  datamem_responder #(.DEPTH_WORDS(DW), .WAIT_CYCLES(WC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_wr_enable (req_wr_enable),
    .req_funct3    (req_funct3),
    .req_addr      (req_addr),
    .req_wr_data   (req_wr_data),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_rd_data  (resp_rd_data),
    .resp_error    (resp_error)
  );

  typedef struct {
    string       name;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [31:0] exp_dat;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string name, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdat,
                              input logic [31:0] exp_dat, input logic exp_err, input int exp_lat);
    vec_t v;
    v.name = name; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdat = wdat;
    v.exp_dat = exp_dat; v.exp_err = exp_err; v.exp_lat = exp_lat;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drives one request, waits for its accept and for resp_valid; leaves the response pending.
  task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdat, output int lat);
    int g;
    @(negedge clk);
    req_valid = 1'b1; req_wr_enable = wr; req_funct3 = f3; req_addr = addr; req_wr_data = wdat;
    g = 0;
    while (!req_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g == 50) check("req_ready_wait", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_resp();
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [31:0] held;

    // Table: DEPTH_WORDS=32 -> 128 bytes; WAIT_CYCLES=1 -> latency 2 single-word, 3 split.
    vecs.push_back(mk("sw_10",      1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        0, 2));
    vecs.push_back(mk("lw_10",      0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 0, 2));
    vecs.push_back(mk("sb_21",      1, 3'b000, 32'h21, 32'h00000080, 32'h0,        0, 2));
    vecs.push_back(mk("lb_21",      0, 3'b000, 32'h21, 32'h0,        32'hFFFFFF80, 0, 2));
    vecs.push_back(mk("lbu_21",     0, 3'b100, 32'h21, 32'h0,        32'h00000080, 0, 2));
    vecs.push_back(mk("sw_0e",      1, 3'b010, 32'h0E, 32'h11223344, 32'h0,        0, 3));
    vecs.push_back(mk("lw_0e",      0, 3'b010, 32'h0E, 32'h0,        32'h11223344, 0, 3));
    vecs.push_back(mk("lh_0f",      0, 3'b001, 32'h0F, 32'h0,        32'h00002233, 0, 3));
    vecs.push_back(mk("lw_10_b",    0, 3'b010, 32'h10, 32'h0,        32'hDEAD1122, 0, 2));
    vecs.push_back(mk("lw_7e_err",  0, 3'b010, 32'h7E, 32'h0,        32'h0,        1, 2));
    vecs.push_back(mk("ld011_err",  0, 3'b011, 32'h10, 32'h0,        32'h0,        1, 2));
    vecs.push_back(mk("st011_err",  1, 3'b011, 32'h10, 32'hFFFFFFFF, 32'h0,        1, 2));
    vecs.push_back(mk("st100_err",  1, 3'b100, 32'h10, 32'hFFFFFFFF, 32'h0,        1, 2));
    vecs.push_back(mk("lw_wrap_err",0, 3'b010, 32'hFFFFFFFE, 32'h0,  32'h0,        1, 2));
    vecs.push_back(mk("lb_80_err",  0, 3'b000, 32'h80, 32'h0,        32'h0,        1, 2));
    vecs.push_back(mk("lw_10_keep", 0, 3'b010, 32'h10, 32'h0,        32'hDEAD1122, 0, 2));
    vecs.push_back(mk("sh_7e",      1, 3'b001, 32'h7E, 32'h00008001, 32'h0,        0, 2));
    vecs.push_back(mk("lh_7e",      0, 3'b001, 32'h7E, 32'h0,        32'hFFFF8001, 0, 2));
    vecs.push_back(mk("lhu_7e",     0, 3'b101, 32'h7E, 32'h0,        32'h00008001, 0, 2));
    vecs.push_back(mk("sh_13",      1, 3'b001, 32'h13, 32'h0000A5C3, 32'h0,        0, 3));
    vecs.push_back(mk("lw_10_c",    0, 3'b010, 32'h10, 32'h0,        32'hC3AD1122, 0, 2));
    vecs.push_back(mk("lhu_13",     0, 3'b101, 32'h13, 32'h0,        32'h0000A5C3, 0, 3));

    // Reset values
    #12;
    check("rst_req_ready",  {31'h0, req_ready},  32'h1);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_rd_data",    resp_rd_data,        32'h0);
    check("rst_error",      {31'h0, resp_error}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      issue(vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdat, lat);
      check({vecs[i].name, "_data"}, resp_rd_data, vecs[i].exp_dat);
      check({vecs[i].name, "_err"},  {31'h0, resp_error}, {31'h0, vecs[i].exp_err});
      check({vecs[i].name, "_lat"},  32'(lat), 32'(vecs[i].exp_lat));
      release_resp();
    end

    // Stall in RESP for 5 cycles
    issue(1'b0, 3'b010, 32'h10, 32'h0, lat);
    held = resp_rd_data;
    check("stall_first_data", held, 32'hC3AD1122);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("stall_valid",     {31'h0, resp_valid}, 32'h1);
      check("stall_data",      resp_rd_data,        32'hC3AD1122);
      check("stall_req_ready", {31'h0, req_ready},  32'h0);
    end
    release_resp();
    check("post_hs_req_ready",  {31'h0, req_ready},  32'h1);
    check("post_hs_resp_valid", {31'h0, resp_valid}, 32'h0);

    // Reset during WAIT of a store: response dropped, no write
    @(negedge clk);
    req_valid = 1'b1; req_wr_enable = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h10; req_wr_data = 32'h55667788;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("wait_req_ready", {31'h0, req_ready}, 32'h0);
    rst_n = 1'b0;
    #1;
    check("midrst_req_ready",  {31'h0, req_ready},  32'h1);
    check("midrst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("midrst_rd_data",    resp_rd_data,        32'h0);
    check("midrst_error",      {31'h0, resp_error}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b0, 3'b010, 32'h10, 32'h0, lat);
    check("midrst_readback", resp_rd_data, 32'hC3AD1122);
    check("midrst_rb_lat",   32'(lat),     32'd2);
    release_resp();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
